spram_arb: RTL and testbench
============================

# spram_arb

Two-client access controller that sits directly upstream of the single-port `spram` block and is the only thing that drives it. It clears the whole array after reset. It then arbitrates read/write requests from two clients (A, B) with round-robin fairness, one RAM access per cycle. It returns read data with a per-port valid strobe.

## Interface
- `ADDR_W`, default 8: RAM address width; depth is 2^ADDR_W.
- `DATA_W`, default 8: RAM word width.
- `CLEAR_ON_RESET`, default 1: when 1, sweep-write `CLEAR_VALUE` to every word after reset.
- `CLEAR_VALUE`, default 0: fill word (DATA_W bits).

Ports:
- `clock`  in  1  sole clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `a_req`, `b_req`  in  1  access request; held with stable fields until ack.
- `a_we`, `b_we`  in  1  1 = write, 0 = read.
- `a_addr`, `b_addr`  in  ADDR_W  word address.
- `a_wdata`, `b_wdata`  in  DATA_W  write data.
- `a_ack`, `b_ack`  out  1  combinational; request accepted this cycle.
- `a_rvalid`, `b_rvalid`  out  1  registered; read data valid this cycle.
- `a_rdata`, `b_rdata`  out  DATA_W  read data; holds last value between reads.
- `ram_rdaddress`, `ram_wraddress`  out  ADDR_W  always driven with the same address.
- `ram_data`  out  DATA_W  write data to RAM.
- `ram_wren`  out  1  RAM write enable.
- `ram_q`  in  DATA_W  RAM registered output.
- `init_done`  out  1  high once clear is complete; acks only when high.

## Operation
- States: CLEAR, SERVE. Reset enters CLEAR if `CLEAR_ON_RESET` = 1, else SERVE.
- CLEAR:
  - A counter `clr_addr` starts at 0.
  - Each cycle: `ram_wren` = 1, addresses = `clr_addr`, `ram_data` = `CLEAR_VALUE`, then increment.
  - After address 2^ADDR_W−1 is written, go to SERVE and set `init_done`.
  - No acks are issued in CLEAR.
- SERVE:
  - Each cycle, grant at most one requester.
  - If only one port requests, that port wins.
  - If both request, grant the port not granted most recently. `last_grant` resets to B, so A wins the first tie.
  - The granted port's addr, we and wdata drive the RAM combinationally. `ram_wren` = granted `we`.
  - With no grant, `ram_wren` = 0 and the addresses hold their last value.
- Read completion: a read granted in cycle t sets that port's `rvalid` in cycle t+1, with `rdata` = `ram_q`. The hold register captures that value, so `rdata` stays stable afterwards.
- Writes produce no rvalid.

## Timing
- Reset values: acks 0, rvalids 0, rdatas 0, `ram_wren` 0, addresses 0, `ram_data` 0, `init_done` 0 (1 if `CLEAR_ON_RESET` = 0), `last_grant` = B, `clr_addr` 0.
- Clear duration: exactly 2^ADDR_W cycles.
  - The first cycle after reset deassertion writes address 0.
  - `init_done` is high in cycle 2^ADDR_W after deassertion.
- Read latency: 1 cycle from ack to rvalid.
- Throughput: back-to-back grants allowed every cycle, including to the same port.
- Write in cycle t followed by a read of the same address in cycle t+1 returns the new data.
- Requester protocol:
  - On ack in cycle t, the requester may present a new request in t+1 or drop `req`.
  - `req` held without ack keeps waiting, with no timeout.
- Reset asserted mid-operation:
  - All state returns to reset values immediately.
  - Pending rvalids are lost; outstanding requests must be reissued.
  - Clear restarts from address 0.

## Structure
- Shared package/include holds the state encoding (CLEAR, SERVE) and the port-select constants (PORT_A, PORT_B).
- One natural sub-module: `rr_arb2`, the two-input round-robin arbiter.
  - Inputs: req pair, `last_grant`.
  - Outputs: one-hot grant.
  - Purely combinational; `last_grant` is registered in the parent.
- The parent holds the FSM, clear counter, rvalid pipeline and rdata hold registers.
- Bench instantiates `spram_arb` with a behavioural 1-cycle-latency RAM model equivalent to `spram`.

## Test plan
- Reset release, ADDR_W=4, CLEAR_VALUE=8'hA5 -> 16 consecutive writes to addresses 0..15; `init_done` high in cycle 16; a later read of address 9 returns 8'hA5.
- A writes 8'h3C to address 5 in cycle t, A reads address 5 in t+1 -> `a_rvalid` high in t+2 with `a_rdata` = 8'h3C, then held while `a_rvalid` = 0.
- A and B both request continuously -> grants alternate A, B, A, B starting with A; no two consecutive grants to the same port.
- B alone reads addresses 1, 2, 3 on three consecutive cycles -> three acks back-to-back; `b_rvalid` high for three cycles carrying the corresponding data.
- Request asserted during CLEAR -> no ack until `init_done`; ack in the first SERVE cycle.
- `reset_n` pulsed low for 1 cycle during traffic, with a read granted the cycle before -> rvalid suppressed, clear restarts at address 0, `init_done` drops to 0.

Source files
------------

// File: rtl/spram_arb_pkg.sv
// Shared definitions for the two-client single-port RAM access controller.
package spram_arb_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/spram_arb_rr_arb2.sv
// Two-input round-robin arbiter; grant bit 0 = port A, bit 1 = port B.
module rr_arb2
  import spram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // On a tie the port that did not win most recently goes first.
      2'b11:   gnt = (last_grant == PORT_B) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/spram_arb.sv
// Sole driver of the single-port RAM: clears the array after reset, then
// arbitrates one access per cycle between clients A and B.
module spram_arb
  import spram_arb_pkg::*;
#(
  parameter int                ADDR_W         = 8,
  parameter int                DATA_W         = 8,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_ack,
  output logic              b_ack,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_rdaddress,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              init_done
);

  localparam state_e RST_STATE = CLEAR_ON_RESET ? CLEAR : SERVE;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_W-1:0] addr_q, ram_addr;
  logic              last_grant_q, last_grant_d;
  logic              a_rvalid_q, b_rvalid_q;
  logic [DATA_W-1:0] a_hold_q, b_hold_q;
  logic [1:0]        req, gnt;

  assign req = (state_q == SERVE) ? {b_req, a_req} : 2'b00;

  rr_arb2 u_arb (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    last_grant_d = last_grant_q;
    a_ack        = 1'b0;
    b_ack        = 1'b0;
    ram_wren     = 1'b0;
    ram_addr     = addr_q;
    ram_data     = '0;
    unique case (state_q)
      CLEAR: begin
        ram_wren   = 1'b1;
        ram_addr   = clr_addr_q;
        ram_data   = CLEAR_VALUE;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == {ADDR_W{1'b1}}) state_d = SERVE;
      end
      SERVE: begin
        a_ack = gnt[0];
        b_ack = gnt[1];
        if (gnt[0]) begin
          ram_addr     = a_addr;
          ram_wren     = a_we;
          ram_data     = a_wdata;
          last_grant_d = PORT_A;
        end else if (gnt[1]) begin
          ram_addr     = b_addr;
          ram_wren     = b_we;
          ram_data     = b_wdata;
          last_grant_d = PORT_B;
        end
      end
      default: state_d = RST_STATE;
    endcase
    // Keep the RAM quiet while reset is held, even though CLEAR is the reset state.
    if (!reset_n) begin
      ram_wren = 1'b0;
      ram_data = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RST_STATE;
      clr_addr_q   <= '0;
      addr_q       <= '0;
      last_grant_q <= PORT_B;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      a_hold_q     <= '0;
      b_hold_q     <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      addr_q       <= ram_addr;
      last_grant_q <= last_grant_d;
      a_rvalid_q   <= a_ack & ~a_we;
      b_rvalid_q   <= b_ack & ~b_we;
      a_hold_q     <= a_rdata;
      b_hold_q     <= b_rdata;
    end
  end

  // Read data comes straight from the registered RAM output on the valid
  // cycle and from the hold register otherwise.
  assign a_rdata       = a_rvalid_q ? ram_q : a_hold_q;
  assign b_rdata       = b_rvalid_q ? ram_q : b_hold_q;
  assign a_rvalid      = a_rvalid_q;
  assign b_rvalid      = b_rvalid_q;
  assign ram_rdaddress = ram_addr;
  assign ram_wraddress = ram_addr;
  assign init_done     = (state_q == SERVE);

endmodule

// File: tb/tb_spram_arb.sv
// Bench for spram_arb with a 1-cycle-latency RAM model and a read-data scoreboard.
module tb_spram_arb;

  localparam int          AW = 4;
  localparam int          DW = 8;
  localparam logic [7:0]  CV = 8'hA5;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ack, b_ack, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] ram_rdaddress, ram_wraddress;
  logic [DW-1:0] ram_data, ram_q;
  logic          ram_wren, init_done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem    [1<<AW];
  logic [DW-1:0] shadow [1<<AW];
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];

  always #5 clock = ~clock;

  spram_arb #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_ack(a_ack), .b_ack(b_ack), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .ram_rdaddress(ram_rdaddress), .ram_wraddress(ram_wraddress),
    .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q), .init_done(init_done)
  );

  // Behavioural single-port RAM, registered output.
  always @(posedge clock) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    ram_q <= mem[ram_rdaddress];
  end

  // Scoreboard: expected read data pushed on each read ack, popped on rvalid.
  always @(negedge clock) begin
    if (!reset_n) begin
      qa.delete();
      qb.delete();
      for (int i = 0; i < (1 << AW); i++) shadow[i] = CV;
    end else begin
      if (a_rvalid) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL sb_a_unexpected: a_rvalid with no read outstanding, rdata=%h", a_rdata);
        end else begin
          logic [DW-1:0] e;
          e = qa.pop_front();
          if (a_rdata !== e) begin
            errors++;
            $display("FAIL sb_a_rdata: got %h expected %h", a_rdata, e);
          end
        end
      end
      if (b_rvalid) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL sb_b_unexpected: b_rvalid with no read outstanding, rdata=%h", b_rdata);
        end else begin
          logic [DW-1:0] e;
          e = qb.pop_front();
          if (b_rdata !== e) begin
            errors++;
            $display("FAIL sb_b_rdata: got %h expected %h", b_rdata, e);
          end
        end
      end
      if (a_ack) begin
        if (a_we) shadow[a_addr] = a_wdata;
        else      qa.push_back(shadow[a_addr]);
      end
      if (b_ack) begin
        if (b_we) shadow[b_addr] = b_wdata;
        else      qb.push_back(shadow[b_addr]);
      end
    end
  end

  task automatic drv_a(input logic r, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    a_req = r; a_we = w; a_addr = ad; a_wdata = d;
  endtask

  task automatic drv_b(input logic r, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    b_req = r; b_we = w; b_addr = ad; b_wdata = d;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drv_a(0, 0, '0, '0);
    drv_b(0, 0, '0, '0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({ram_wren, ram_data, ram_rdaddress, ram_wraddress, init_done, a_ack, b_ack,
         a_rvalid, b_rvalid, a_rdata, b_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_values: wren=%b data=%h addr=%h/%h init=%b ack=%b%b rv=%b%b rd=%h/%h expected all 0",
               ram_wren, ram_data, ram_rdaddress, ram_wraddress, init_done, a_ack, b_ack,
               a_rvalid, b_rvalid, a_rdata, b_rdata);
    end
    @(posedge clock); #1 reset_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      checks++;
      if (!(ram_wren === 1'b1 && ram_wraddress === AW'(k) && ram_rdaddress === AW'(k) &&
            ram_data === CV && init_done === 1'b0)) begin
        errors++;
        $display("FAIL clear_cycle%0d: wren=%b addr=%h/%h data=%h init=%b expected 1 %h %h 0",
                 k, ram_wren, ram_wraddress, ram_rdaddress, ram_data, init_done, k[3:0], CV);
      end
    end
    @(negedge clock);
    checks++;
    if (!(init_done === 1'b1 && ram_wren === 1'b0)) begin
      errors++;
      $display("FAIL clear_done: init_done=%b wren=%b expected 1 0", init_done, ram_wren);
    end
  endtask

  // Both ports read address 9 continuously; grants must alternate starting with A.
  task automatic test_alternate();
    @(posedge clock); #1;
    drv_a(1, 0, 4'd9, '0);
    drv_b(1, 0, 4'd9, '0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      checks++;
      if (a_ack !== (k % 2 == 0) || b_ack !== (k % 2 == 1)) begin
        errors++;
        $display("FAIL alternate_k%0d: a_ack=%b b_ack=%b expected %b %b",
                 k, a_ack, b_ack, (k % 2 == 0), (k % 2 == 1));
      end
      @(posedge clock); #1;
    end
    drv_a(0, 0, '0, '0);
    drv_b(0, 0, '0, '0);
    @(negedge clock);
  endtask

  task automatic test_write_read();
    @(posedge clock); #1 drv_a(1, 1, 4'd5, 8'h3C);
    @(negedge clock);
    checks++;
    if (a_ack !== 1'b1 || ram_wren !== 1'b1) begin
      errors++;
      $display("FAIL wr_ack: a_ack=%b wren=%b expected 1 1", a_ack, ram_wren);
    end
    @(posedge clock); #1 drv_a(1, 0, 4'd5, '0);
    @(negedge clock);
    checks++;
    if (a_ack !== 1'b1 || ram_wren !== 1'b0) begin
      errors++;
      $display("FAIL rd_ack: a_ack=%b wren=%b expected 1 0", a_ack, ram_wren);
    end
    @(posedge clock); #1 drv_a(0, 0, '0, '0);
    @(negedge clock);
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL raw_data: a_rvalid=%b a_rdata=%h expected 1 3c", a_rvalid, a_rdata);
    end
    repeat (2) begin
      @(negedge clock);
      checks++;
      if (a_rvalid !== 1'b0 || a_rdata !== 8'h3C) begin
        errors++;
        $display("FAIL rdata_hold: a_rvalid=%b a_rdata=%h expected 0 3c", a_rvalid, a_rdata);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] ex [3];
    ex[0] = 8'h11; ex[1] = 8'h22; ex[2] = 8'h33;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (i < 3) drv_b(1, 1, AW'(i + 1), ex[i]);
      else       drv_b(1, 0, AW'(i - 2), '0);
      @(negedge clock);
      checks++;
      if (b_ack !== 1'b1 || b_rvalid !== (i > 3) || (i > 3 && b_rdata !== ex[(i > 3) ? i - 4 : 0])) begin
        errors++;
        $display("FAIL b2b_cycle%0d: b_ack=%b b_rvalid=%b b_rdata=%h expected 1 %b %h",
                 i, b_ack, b_rvalid, b_rdata, (i > 3), ex[(i > 3) ? i - 4 : 0]);
      end
    end
    @(posedge clock); #1 drv_b(0, 0, '0, '0);
    @(negedge clock);
    checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 8'h33) begin
      errors++;
      $display("FAIL b2b_last: b_rvalid=%b b_rdata=%h expected 1 33", b_rvalid, b_rdata);
    end
    @(negedge clock);
    checks++;
    if (b_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: b_rvalid=%b expected 0", b_rvalid);
    end
  endtask

  // Requests held through a fresh clear: no ack until init_done, then A wins the first tie.
  task automatic test_clear_wait();
    @(posedge clock); #1;
    reset_n = 1'b0;
    drv_a(1, 0, 4'd3, '0);
    drv_b(1, 0, 4'd4, '0);
    @(posedge clock); #1 reset_n = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clock);
      checks++;
      if (a_ack !== (k == 16) || b_ack !== 1'b0 || init_done !== (k == 16) ||
          (k == 16 && ram_rdaddress !== 4'd3)) begin
        errors++;
        $display("FAIL clear_wait_k%0d: a_ack=%b b_ack=%b init=%b addr=%h expected %b 0 %b",
                 k, a_ack, b_ack, init_done, ram_rdaddress, (k == 16), (k == 16));
      end
    end
    @(posedge clock); #1 drv_a(0, 0, '0, '0);
    @(negedge clock);
    checks++;
    if (b_ack !== 1'b1) begin
      errors++;
      $display("FAIL clear_wait_b: b_ack=%b expected 1", b_ack);
    end
    @(posedge clock); #1 drv_b(0, 0, '0, '0);
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    @(posedge clock); #1 drv_a(1, 0, 4'd7, '0);
    @(negedge clock);
    checks++;
    if (a_ack !== 1'b1) begin
      errors++;
      $display("FAIL mid_ack: a_ack=%b expected 1", a_ack);
    end
    @(posedge clock); #1;
    reset_n = 1'b0;
    drv_a(0, 0, '0, '0);
    @(negedge clock);
    checks++;
    if (a_rvalid !== 1'b0 || init_done !== 1'b0 || a_rdata !== '0 || ram_wren !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: a_rvalid=%b init=%b a_rdata=%h wren=%b expected 0 0 00 0",
               a_rvalid, init_done, a_rdata, ram_wren);
    end
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (ram_wren !== 1'b1 || ram_wraddress !== '0 || a_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_restart: wren=%b addr=%h a_rvalid=%b expected 1 0 0",
               ram_wren, ram_wraddress, a_rvalid);
    end
    repeat (15) @(negedge clock);
    @(negedge clock);
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL mid_init_done: init_done=%b expected 1", init_done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alternate();
    test_write_read();
    test_back_to_back();
    test_clear_wait();
    test_reset_mid();
    repeat (2) @(negedge clock);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: outstanding reads a=%0d b=%0d expected 0 0", qa.size(), qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
